// File: rtl/spi_boot_loader_pkg.sv
// spi_boot_loader_pkg
//    Shared constants for the SPI boot loader: frame-header length,
//    frame-FSM state encoding and write-engine state encoding.
//    No ports; imported by spi_slave_rx and spi_boot_loader.
package spi_boot_loader_pkg;

   // Header bytes: start_addr[23:0] then end_addr[23:0], LSB byte first.
   localparam int HDR_BYTES = 6;

   typedef logic [2:0] frame_state_t;
   localparam frame_state_t FS_HDR0 = 3'd0;
   localparam frame_state_t FS_HDR1 = 3'd1;
   localparam frame_state_t FS_HDR2 = 3'd2;
   localparam frame_state_t FS_HDR3 = 3'd3;
   localparam frame_state_t FS_HDR4 = 3'd4;
   localparam frame_state_t FS_HDR5 = 3'd5;
   // Data phase follows directly after the last header byte.
   localparam frame_state_t FS_DATA = 3'(HDR_BYTES);
   localparam frame_state_t FS_DONE = 3'd7;

   typedef logic [1:0] wr_state_t;
   localparam wr_state_t W_IDLE  = 2'd0;
   localparam wr_state_t W_SETUP = 2'd1;
   localparam wr_state_t W_PULSE = 2'd2;
   localparam wr_state_t W_HOLD  = 2'd3;

endpackage

// File: rtl/spi_boot_loader_spi_slave_rx.sv
// spi_slave_rx
//    SPI mode-0 receiver running entirely in the clk domain. The
//    asynchronous ss/sclk/mosi pins are double-registered, sclk rising
//    edges are detected from the synchronised stream and bits are
//    shifted in MSB first. Every 8th edge emits a byte with a 1-cycle
//    byte_valid pulse. A high synchronised ss aborts any partial byte.
// Ports:
//    clk, rst          system clock, synchronous active-high reset
//    arm_ss/sclk/mosi  raw SPI pins (asynchronous)
//    rx_byte           last completed byte
//    byte_valid        1-cycle strobe, rx_byte valid
//    ss_s              synchronised slave select (active low)
module spi_slave_rx
   import spi_boot_loader_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       arm_ss,
   input  logic       arm_sclk,
   input  logic       arm_mosi,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       ss_s
);

   logic       ss_m_r;
   logic       sclk_m_r;
   logic       sclk_s2_r;
   logic       sclk_s3_r;
   logic       mosi_m_r;
   logic       mosi_s2_r;
   logic [6:0] shift_r;
   logic [2:0] bit_cnt_r;
   logic       sclk_rise_s;

   assign sclk_rise_s = sclk_s2_r & ~sclk_s3_r;

   // Synchronisers; ss resets high (deselected) so reset never looks like a frame start.
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_m_r    <= 1'b1;
         ss_s      <= 1'b1;
         sclk_m_r  <= 1'b0;
         sclk_s2_r <= 1'b0;
         sclk_s3_r <= 1'b0;
         mosi_m_r  <= 1'b0;
         mosi_s2_r <= 1'b0;
      end else begin
         ss_m_r    <= arm_ss;
         ss_s      <= ss_m_r;
         sclk_m_r  <= arm_sclk;
         sclk_s2_r <= sclk_m_r;
         sclk_s3_r <= sclk_s2_r;
         mosi_m_r  <= arm_mosi;
         mosi_s2_r <= mosi_m_r;
      end
   end

   // Bit shifter and byte framing.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_r    <= 7'd0;
         bit_cnt_r  <= 3'd0;
         rx_byte    <= 8'd0;
         byte_valid <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (ss_s) begin
            shift_r   <= 7'd0;
            bit_cnt_r <= 3'd0;
         end else if (sclk_rise_s) begin
            shift_r   <= {shift_r[5:0], mosi_s2_r};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
               rx_byte    <= {shift_r, mosi_s2_r};
               byte_valid <= 1'b1;
            end else begin
               rx_byte    <= rx_byte;
            end
         end else begin
            shift_r   <= shift_r;
            bit_cnt_r <= bit_cnt_r;
         end
      end
   end

endmodule

// File: rtl/spi_boot_loader.sv
// spi_boot_loader
//    Receives a boot image over SPI and writes it byte by byte into an
//    external asynchronous SRAM. Frame: start_addr (3 bytes), end_addr
//    (3 bytes), then end-start+1 data bytes, all LSB byte first. Holds
//    the CPU in reset (boot_busy) until a frame has been seen, ss has
//    stayed high for RELEASE_CYCLES and the last write has completed.
// Ports:
//    clk100, RESET_I            clock, synchronous active-high reset
//    arm_ss/arm_sclk/arm_mosi   SPI slave pins from the ARM
//    ram_addr/ram_data          SRAM address / write data
//    ram_we_b/ram_cs_b/ram_oe_b SRAM strobes, active low (oe_b tied high)
//    boot_busy                  loader owns SRAM, CPU held in reset
//    boot_error                 sticky byte-overrun flag
module spi_boot_loader
   import spi_boot_loader_pkg::*;
#(
   parameter int WE_CYCLES      = 3,
   parameter int RELEASE_CYCLES = 1000,
   parameter int ADDR_W         = 18
) (
   input  logic              clk100,
   input  logic              RESET_I,
   input  logic              arm_ss,
   input  logic              arm_sclk,
   input  logic              arm_mosi,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_data,
   output logic              ram_we_b,
   output logic              ram_cs_b,
   output logic              ram_oe_b,
   output logic              boot_busy,
   output logic              boot_error
);

   localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
   localparam int REL_W = $clog2(RELEASE_CYCLES + 1);
   localparam logic [REL_W-1:0] REL_MAX = REL_W'(RELEASE_CYCLES);

   logic [7:0]        rx_byte_s;
   logic              rx_valid_s;
   logic              ss_s;
   logic              ss_prev_r;
   logic              ss_rise_s;
   logic              ss_fall_s;

   frame_state_t      fstate_r;
   logic [23:0]       start_r;
   logic [23:0]       end_r;
   logic [23:0]       ptr_r;
   logic [23:0]       end_full_s;
   logic              frame_seen_r;

   logic              hold_valid_r;
   logic [ADDR_W-1:0] hold_addr_r;
   logic [7:0]        hold_data_r;
   wr_state_t         wstate_r;
   logic [CNT_W-1:0]  we_cnt_r;
   logic              wr_req_s;
   logic              take_s;

   logic [REL_W-1:0]  rel_cnt_r;

   spi_slave_rx u_rx (
      .clk        (clk100),
      .rst        (RESET_I),
      .arm_ss     (arm_ss),
      .arm_sclk   (arm_sclk),
      .arm_mosi   (arm_mosi),
      .rx_byte    (rx_byte_s),
      .byte_valid (rx_valid_s),
      .ss_s       (ss_s)
   );

   assign ram_oe_b   = 1'b1;
   assign ss_rise_s  = ss_s & ~ss_prev_r;
   assign ss_fall_s  = ~ss_s & ss_prev_r;
   // end_addr as it will be once the current (last header) byte lands.
   assign end_full_s = {rx_byte_s, end_r[15:0]};
   // A byte racing a deselect is dropped along with the frame.
   assign wr_req_s   = rx_valid_s & (fstate_r == FS_DATA) & ~ss_rise_s;
   // The holding register is flushed on deselect, so no pickup that cycle.
   assign take_s     = (wstate_r == W_IDLE) & hold_valid_r & ~ss_rise_s;

   // Previous synchronised ss for edge detection.
   always_ff @(posedge clk100) begin
      if (RESET_I) begin
         ss_prev_r <= 1'b1;
      end else begin
         ss_prev_r <= ss_s;
      end
   end

   // Frame FSM: header capture, data pointer, frame_seen.
   always_ff @(posedge clk100) begin
      if (RESET_I) begin
         fstate_r     <= FS_HDR0;
         start_r      <= 24'd0;
         end_r        <= 24'd0;
         ptr_r        <= 24'd0;
         frame_seen_r <= 1'b0;
      end else begin
         if (ss_fall_s) begin
            frame_seen_r <= 1'b0;
         end else begin
            frame_seen_r <= frame_seen_r;
         end
         if (ss_rise_s) begin
            fstate_r <= FS_HDR0;
         end else if (rx_valid_s) begin
            case (fstate_r)
               FS_HDR0: begin start_r[7:0]   <= rx_byte_s; fstate_r <= FS_HDR1; end
               FS_HDR1: begin start_r[15:8]  <= rx_byte_s; fstate_r <= FS_HDR2; end
               FS_HDR2: begin start_r[23:16] <= rx_byte_s; fstate_r <= FS_HDR3; end
               FS_HDR3: begin end_r[7:0]     <= rx_byte_s; fstate_r <= FS_HDR4; end
               FS_HDR4: begin end_r[15:8]    <= rx_byte_s; fstate_r <= FS_HDR5; end
               FS_HDR5: begin
                  end_r        <= end_full_s;
                  ptr_r        <= start_r;
                  frame_seen_r <= 1'b1;
                  if (start_r > end_full_s) begin
                     fstate_r <= FS_DONE;
                  end else begin
                     fstate_r <= FS_DATA;
                  end
               end
               FS_DATA: begin
                  ptr_r <= ptr_r + 24'd1;
                  if (ptr_r == end_r) begin
                     fstate_r <= FS_DONE;
                  end else begin
                     fstate_r <= FS_DATA;
                  end
               end
               FS_DONE: fstate_r <= FS_DONE;
               default: fstate_r <= FS_HDR0;
            endcase
         end else begin
            fstate_r <= fstate_r;
         end
      end
   end

   // Holding register plus SRAM write strobe sequencer.
   always_ff @(posedge clk100) begin
      if (RESET_I) begin
         hold_valid_r <= 1'b0;
         hold_addr_r  <= {ADDR_W{1'b0}};
         hold_data_r  <= 8'd0;
         boot_error   <= 1'b0;
         wstate_r     <= W_IDLE;
         we_cnt_r     <= {CNT_W{1'b0}};
         ram_addr     <= {ADDR_W{1'b0}};
         ram_data     <= 8'd0;
         ram_we_b     <= 1'b1;
         ram_cs_b     <= 1'b1;
      end else begin
         if (ss_rise_s) begin
            hold_valid_r <= 1'b0;
         end else if (wr_req_s) begin
            if (hold_valid_r && !take_s) begin
               boot_error <= 1'b1;
            end else begin
               hold_valid_r <= 1'b1;
               hold_addr_r  <= ptr_r[ADDR_W-1:0];
               hold_data_r  <= rx_byte_s;
            end
         end else if (take_s) begin
            hold_valid_r <= 1'b0;
         end else begin
            hold_valid_r <= hold_valid_r;
         end

         case (wstate_r)
            W_IDLE: begin
               if (take_s) begin
                  ram_addr <= hold_addr_r;
                  ram_data <= hold_data_r;
                  ram_cs_b <= 1'b0;
                  wstate_r <= W_SETUP;
               end else begin
                  wstate_r <= W_IDLE;
               end
            end
            W_SETUP: begin
               ram_we_b <= 1'b0;
               we_cnt_r <= CNT_W'(WE_CYCLES - 1);
               wstate_r <= W_PULSE;
            end
            W_PULSE: begin
               if (we_cnt_r == {CNT_W{1'b0}}) begin
                  ram_we_b <= 1'b1;
                  wstate_r <= W_HOLD;
               end else begin
                  we_cnt_r <= we_cnt_r - CNT_W'(1);
               end
            end
            W_HOLD: begin
               ram_cs_b <= 1'b1;
               wstate_r <= W_IDLE;
            end
            default: begin
               ram_we_b <= 1'b1;
               ram_cs_b <= 1'b1;
               wstate_r <= W_IDLE;
            end
         endcase
      end
   end

   // ss-high dwell counter and boot_busy hand-over.
   always_ff @(posedge clk100) begin
      if (RESET_I) begin
         rel_cnt_r <= {REL_W{1'b0}};
         boot_busy <= 1'b1;
      end else begin
         if (!ss_s) begin
            rel_cnt_r <= {REL_W{1'b0}};
         end else if (rel_cnt_r != REL_MAX) begin
            rel_cnt_r <= rel_cnt_r + REL_W'(1);
         end else begin
            rel_cnt_r <= rel_cnt_r;
         end
         if (ss_fall_s) begin
            boot_busy <= 1'b1;
         end else if (frame_seen_r && (rel_cnt_r == REL_MAX) &&
                      (wstate_r == W_IDLE) && !hold_valid_r) begin
            boot_busy <= 1'b0;
         end else begin
            boot_busy <= boot_busy;
         end
      end
   end

endmodule

// File: doc/spi_boot_loader.md
Name: spi_boot_loader

Overview:
- SPI slave that receives ROM/RAM images from the board ARM over arm_ss/arm_sclk/arm_mosi and writes them byte-by-byte into the external 256K x 8 SRAM.
- Sits at the top level, muxed onto the SRAM ADR/DAT/RAMWE_b/RAMCS_b pins while it owns the bus.
- Holds the BBC core in reset (boot_busy) until loading has finished.
- Frame format, LSB byte first: start_addr[23:0] (3 bytes), end_addr[23:0] (3 bytes), then (end - start + 1) data bytes.

Parameters:
- WE_CYCLES, 3, number of clk100 cycles RAMWE_b is held low per write.
- RELEASE_CYCLES, 1000, number of cycles arm_ss must stay high after a completed frame before boot_busy drops.
- ADDR_W, 18, SRAM address width; the upper received address bits are discarded.

Ports:
- clk100  in  1  system clock, 100 MHz.
- RESET_I  in  1  reset; synchronous, active-high.
- arm_ss  in  1  SPI select, active low, asynchronous.
- arm_sclk  in  1  SPI clock, asynchronous, up to 20 MHz. MOSI changes on the falling edge and is sampled on the rising edge; MSB first.
- arm_mosi  in  1  SPI data, asynchronous.
- ram_addr  out  ADDR_W  SRAM address.
- ram_data  out  8  SRAM write data.
- ram_we_b  out  1  SRAM write enable, active low.
- ram_cs_b  out  1  SRAM chip select, active low.
- ram_oe_b  out  1  SRAM output enable; constant 1.
- boot_busy  out  1  1 = loader owns the SRAM and the CPU is held in reset.
- boot_error  out  1  sticky byte-overrun flag.

Behaviour:
- Reset values:
  - ram_addr = 0, ram_data = 0.
  - ram_we_b = 1, ram_cs_b = 1, ram_oe_b = 1.
  - boot_busy = 1, boot_error = 0.
  - bit counter = 0, byte state = HDR0.
- Input synchronisation:
  - ss, sclk and mosi each pass through a 2-FF synchroniser.
  - A sclk rising edge is detected as s2 & !s3.
  - mosi_s2 is shifted in on that cycle.
  - Synchronised ss high clears the bit counter and the partial byte.
- Byte assembly:
  - 8 rising edges produce a byte and a 1-cycle byte_valid pulse.
  - At 20 MHz sclk this gives one byte per 40 clocks.
- Frame FSM: HDR0..HDR2 load start_addr; HDR3..HDR5 load end_addr; then DATA; then DONE.
  - On byte 6 the FSM enters DATA with ptr = start_addr.
  - If start_addr > end_addr, it enters DONE directly and writes nothing.
  - DATA: each byte issues a write at ptr, then ptr increments (24-bit).
  - After the write at ptr == end_addr the FSM enters DONE.
  - DONE: all further bytes are ignored.
  - A synchronised ss rising edge in any state returns the FSM to HDR0.
  - A frame that reached at least DATA marks frame_seen.
- Write engine: one-entry holding register with states W_IDLE, W_SETUP, W_PULSE, W_HOLD.
  - W_SETUP (1 cycle): drive addr/data, ram_cs_b = 0.
  - W_PULSE (WE_CYCLES cycles): ram_we_b = 0.
  - W_HOLD (1 cycle): ram_we_b = 1 with addr/data/cs still held, so the SRAM latches on the rising edge of WE.
  - Then ram_cs_b = 1 and the engine returns to W_IDLE.
  - ram_addr and ram_data hold their last values while idle.
  - A byte_valid arriving while the engine is busy and the holding register is already full sets boot_error; that byte is dropped.
- ss rising edge during a write: the current write completes normally and the holding register is flushed.
- boot_busy:
  - Clears once frame_seen is set, ss has been continuously high for RELEASE_CYCLES, and the write engine is idle.
  - Sets again on any later ss falling edge, so a re-load is allowed.
  - frame_seen clears on ss fall.
- RESET_I mid-frame: all state returns to reset values, including an in-progress write (we/cs deassert on the next edge).
- Address wrap: ptr increments over 24 bits; only the low ADDR_W bits are driven, so 0x3FFFF + 1 wraps to 0 on the pins.

Decomposition:
- Shared package holds:
  - frame-state enum (HDR0..HDR5, DATA, DONE);
  - write-state enum (W_IDLE, W_SETUP, W_PULSE, W_HOLD);
  - HDR_BYTES = 6.
- One natural sub-module: spi_slave_rx. It contains the synchronisers, edge detect and shift register, and outputs byte + byte_valid + ss_s.

Test Plan:
- Frame start=0x00C000, end=0x00C003, data A9 00 8D 20 at 20 MHz sclk -> SRAM[0xC000..0xC003] = A9 00 8D 20; exactly 4 WE rising edges with cs low; boot_busy falls 1000 cycles after ss rises.
- Full 16 KB image 0x00C000..0x00FFFF, incrementing pattern -> every byte matches; boot_error = 0; no write outside the range.
- start=0x000010, end=0x00000F (start > end), then 3 extra bytes -> zero WE pulses; FSM in DONE; boot_busy releases normally.
- ss raised after 3 bits of the 2nd data byte, then a new frame start=0x100, end=0x100, data 55 -> only the 1st byte of the first frame written; SRAM[0x100] = 55.
- start=0x03FFFF, end=0x040000, data 11 22 -> SRAM[0x3FFFF] = 11; SRAM[0x00000] = 22 (wrap).
- RESET_I pulsed during W_PULSE -> ram_we_b = 1 and ram_cs_b = 1 next cycle; boot_busy = 1; FSM in HDR0.
